// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//
// Purpose:
//   Control side of the PC select mux. Every cycle it decides how the program
//   counter advances (sequential, first instruction, branch/call target) and
//   drives the mux select and enable. It also owns three multi-cycle flows:
//     - boot: read the reset vector from memory, then load it into the PC
//     - interrupt entry: flush, save and push the return PC, read the
//       interrupt vector, then jump to it
//     - ISR return (reti): jump to the popped return address, leave the ISR
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   pc_now                   current PC, saved as the return address on entry
//   stall                    fetch freeze request from the hazard unit
//   branch_taken/_target     resolved jump/call/taken branch and its target
//   reti_valid/reti_addr     resolved return-from-interrupt and return address
//   int_req                  external interrupt level (synchronous)
//   vec_rd_ack/_data         memory read completion and data
//   push_ack                 stack push accepted
//   pc_sel                   mux select: 00 next, 01 first instr, 11 branch/call
//                            (10 = zero is reserved and never driven)
//   pc_en                    PC register update enable
//   first_instruction_addr   latched reset vector
//   branch_call_addr         jump target presented to the mux
//   flush                    squash fetch/decode
//   vec_rd_req/_addr         memory read request (held until ack) and address
//   push_req/push_data       stack push request (held until ack) and return PC
//   int_ack                  one-cycle pulse when an interrupt is accepted
//   in_isr                   high while an interrupt is being serviced
// -----------------------------------------------------------------------------
module pc_sequencer #(
    parameter int            AW             = 32,
    parameter logic [AW-1:0] RESET_VEC_ADDR = 32'h0000_0000,
    parameter logic [AW-1:0] INT_VEC_ADDR   = 32'h0000_0001
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] pc_now,
    input  logic          stall,
    input  logic          branch_taken,
    input  logic [AW-1:0] branch_target,
    input  logic          reti_valid,
    input  logic [AW-1:0] reti_addr,
    input  logic          int_req,
    input  logic          vec_rd_ack,
    input  logic [AW-1:0] vec_rd_data,
    input  logic          push_ack,
    output logic [1:0]    pc_sel,
    output logic          pc_en,
    output logic [AW-1:0] first_instruction_addr,
    output logic [AW-1:0] branch_call_addr,
    output logic          flush,
    output logic          vec_rd_req,
    output logic [AW-1:0] vec_rd_addr,
    output logic          push_req,
    output logic [AW-1:0] push_data,
    output logic          int_ack,
    output logic          in_isr
);

    // Mux select encodings (2'b10 selects zero and is reserved).
    localparam logic [1:0] SEL_NEXT   = 2'b00;
    localparam logic [1:0] SEL_FIRST  = 2'b01;
    localparam logic [1:0] SEL_BRANCH = 2'b11;

    typedef enum logic [2:0] {
        BOOT_RD,
        BOOT_LD,
        RUN,
        INT_PUSH,
        INT_RD,
        INT_JMP
    } state_t;

    state_t        state_q,        state_d;
    logic [AW-1:0] first_addr_q,   first_addr_d;
    logic [AW-1:0] isr_vec_q,      isr_vec_d;
    logic [AW-1:0] saved_pc_q,     saved_pc_d;
    logic          in_isr_q,       in_isr_d;
    logic          int_pend_q,     int_pend_d;
    logic          int_req_prev_q, int_req_prev_d;
    logic          int_edge;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= BOOT_RD;
            first_addr_q   <= '0;
            isr_vec_q      <= '0;
            saved_pc_q     <= '0;
            in_isr_q       <= 1'b0;
            int_pend_q     <= 1'b0;
            int_req_prev_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            first_addr_q   <= first_addr_d;
            isr_vec_q      <= isr_vec_d;
            saved_pc_q     <= saved_pc_d;
            in_isr_q       <= in_isr_d;
            int_pend_q     <= int_pend_d;
            int_req_prev_q <= int_req_prev_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        first_addr_d   = first_addr_q;
        isr_vec_d      = isr_vec_q;
        saved_pc_d     = saved_pc_q;
        in_isr_d       = in_isr_q;
        int_req_prev_d = int_req;

        // A fresh edge always sets the pending flag, even during an
        // interrupt sequence; only acceptance in RUN clears it.
        int_edge   = int_req && !int_req_prev_q;
        int_pend_d = int_pend_q || int_edge;

        pc_sel           = SEL_NEXT;
        pc_en            = 1'b0;
        branch_call_addr = '0;
        flush            = 1'b0;
        vec_rd_req       = 1'b0;
        vec_rd_addr      = RESET_VEC_ADDR;
        push_req         = 1'b0;
        push_data        = '0;
        int_ack          = 1'b0;

        // While reset is held the outputs stay quiet so that any outstanding
        // request is dropped at once rather than waiting for its ack.
        if (!rst) begin
            case (state_q)
                BOOT_RD: begin
                    vec_rd_req  = 1'b1;
                    vec_rd_addr = RESET_VEC_ADDR;
                    if (vec_rd_ack) begin
                        first_addr_d = vec_rd_data;
                        state_d      = BOOT_LD;
                    end
                end

                BOOT_LD: begin
                    pc_sel  = SEL_FIRST;
                    pc_en   = 1'b1;
                    state_d = RUN;
                end

                RUN: begin
                    // Redirects beat stall; an interrupt waits for a cycle
                    // with no redirect and no stall so the saved PC is the
                    // address that would really execute next.
                    if (branch_taken) begin
                        pc_sel           = SEL_BRANCH;
                        branch_call_addr = branch_target;
                        pc_en            = 1'b1;
                        flush            = 1'b1;
                    end else if (reti_valid) begin
                        pc_sel           = SEL_BRANCH;
                        branch_call_addr = reti_addr;
                        pc_en            = 1'b1;
                        flush            = 1'b1;
                        in_isr_d         = 1'b0;
                    end else if (int_pend_q && !in_isr_q && !stall) begin
                        flush      = 1'b1;
                        int_ack    = 1'b1;
                        saved_pc_d = pc_now;
                        in_isr_d   = 1'b1;
                        int_pend_d = int_edge;
                        state_d    = INT_PUSH;
                    end else if (!stall) begin
                        pc_sel = SEL_NEXT;
                        pc_en  = 1'b1;
                    end
                end

                INT_PUSH: begin
                    push_req  = 1'b1;
                    push_data = saved_pc_q;
                    if (push_ack) begin
                        state_d = INT_RD;
                    end
                end

                INT_RD: begin
                    vec_rd_req  = 1'b1;
                    vec_rd_addr = INT_VEC_ADDR;
                    if (vec_rd_ack) begin
                        isr_vec_d = vec_rd_data;
                        state_d   = INT_JMP;
                    end
                end

                INT_JMP: begin
                    pc_sel           = SEL_BRANCH;
                    branch_call_addr = isr_vec_q;
                    pc_en            = 1'b1;
                    state_d          = RUN;
                end

                default: begin
                    state_d = BOOT_RD;
                end
            endcase
        end
    end

    assign first_instruction_addr = first_addr_q;
    assign in_isr                 = in_isr_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
//
// Purpose:
//   Self-checking bench for pc_sequencer. Each scenario task queues per-cycle
//   stimulus rows together with the outputs the sequencer must show in that
//   cycle; the expectation enters the scoreboard when its stimulus is driven
//   and is popped and compared once the outputs have settled.
//
// Ports: none (top-level bench).
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

    localparam int          AW = 32;
    localparam logic [31:0] RV = 32'h0000_0000;
    localparam logic [31:0] IV = 32'h0000_0001;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] pc_now;
    logic          stall;
    logic          branch_taken;
    logic [AW-1:0] branch_target;
    logic          reti_valid;
    logic [AW-1:0] reti_addr;
    logic          int_req;
    logic          vec_rd_ack;
    logic [AW-1:0] vec_rd_data;
    logic          push_ack;
    logic [1:0]    pc_sel;
    logic          pc_en;
    logic [AW-1:0] first_instruction_addr;
    logic [AW-1:0] branch_call_addr;
    logic          flush;
    logic          vec_rd_req;
    logic [AW-1:0] vec_rd_addr;
    logic          push_req;
    logic [AW-1:0] push_data;
    logic          int_ack;
    logic          in_isr;

    always #5 clk = ~clk;

    pc_sequencer #(
        .AW             (AW),
        .RESET_VEC_ADDR (RV),
        .INT_VEC_ADDR   (IV)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .pc_now                 (pc_now),
        .stall                  (stall),
        .branch_taken           (branch_taken),
        .branch_target          (branch_target),
        .reti_valid             (reti_valid),
        .reti_addr              (reti_addr),
        .int_req                (int_req),
        .vec_rd_ack             (vec_rd_ack),
        .vec_rd_data            (vec_rd_data),
        .push_ack               (push_ack),
        .pc_sel                 (pc_sel),
        .pc_en                  (pc_en),
        .first_instruction_addr (first_instruction_addr),
        .branch_call_addr       (branch_call_addr),
        .flush                  (flush),
        .vec_rd_req             (vec_rd_req),
        .vec_rd_addr            (vec_rd_addr),
        .push_req               (push_req),
        .push_data              (push_data),
        .int_ack                (int_ack),
        .in_isr                 (in_isr)
    );

    typedef struct packed {
        logic [1:0]  pc_sel;
        logic        pc_en;
        logic        flush;
        logic        int_ack;
        logic        vec_rd_req;
        logic        push_req;
        logic        in_isr;
        logic [31:0] bca;
        logic [31:0] rd_addr;
        logic [31:0] push_data;
        logic [31:0] first_addr;
    } out_t;

    typedef struct packed {
        logic        rst;
        logic        stall;
        logic        int_req;
        logic        br;
        logic [31:0] bt;
        logic        rv;
        logic [31:0] ra;
        logic        rack;
        logic [31:0] rdat;
        logic        pack;
        logic [31:0] pc;
    } stim_t;

    typedef struct {
        string tag;
        out_t  v;
        out_t  m;
    } exp_t;

    out_t  obs;
    stim_t stim_q[$];
    exp_t  pend_q[$];
    exp_t  sb[$];
    int    checks = 0;
    int    errors = 0;

    assign obs = {pc_sel, pc_en, flush, int_ack, vec_rd_req, push_req, in_isr,
                  branch_call_addr, vec_rd_addr, push_data, first_instruction_addr};

    function automatic stim_t st(logic r, logic stl, logic irq, logic br, logic [31:0] bt,
                                 logic rv, logic [31:0] ra, logic rack, logic [31:0] rdat,
                                 logic pack, logic [31:0] pc);
        stim_t s;
        s.rst = r;  s.stall = stl; s.int_req = irq; s.br = br; s.bt = bt;
        s.rv = rv;  s.ra = ra;     s.rack = rack;   s.rdat = rdat;
        s.pack = pack; s.pc = pc;
        return s;
    endfunction

    // am selects the extra fields to check: [4] pc_sel even when pc_en=0,
    // [3] first_addr, [2] rd_addr, [1] push_data, [0] branch_call_addr.
    task automatic row(input stim_t s, input string tag, input logic [1:0] sel,
                       input logic en, input logic fl, input logic ack, input logic rreq,
                       input logic preq, input logic isr, input logic [4:0] am,
                       input logic [31:0] bca, input logic [31:0] rd,
                       input logic [31:0] pd, input logic [31:0] fa);
        exp_t e;
        e.tag = tag;
        e.v = '0;
        e.v.pc_sel = sel; e.v.pc_en = en; e.v.flush = fl; e.v.int_ack = ack;
        e.v.vec_rd_req = rreq; e.v.push_req = preq; e.v.in_isr = isr;
        e.v.bca = bca; e.v.rd_addr = rd; e.v.push_data = pd; e.v.first_addr = fa;
        e.m = '0;
        e.m.pc_en = 1'b1; e.m.flush = 1'b1; e.m.int_ack = 1'b1;
        e.m.vec_rd_req = 1'b1; e.m.push_req = 1'b1; e.m.in_isr = 1'b1;
        if (en || am[4]) e.m.pc_sel = '1;
        if (am[3]) e.m.first_addr = '1;
        if (am[2]) e.m.rd_addr = '1;
        if (am[1]) e.m.push_data = '1;
        if (am[0]) e.m.bca = '1;
        stim_q.push_back(s);
        pend_q.push_back(e);
    endtask

    task automatic drive(input stim_t s);
        rst           = s.rst;
        stall         = s.stall;
        int_req       = s.int_req;
        branch_taken  = s.br;
        branch_target = s.bt;
        reti_valid    = s.rv;
        reti_addr     = s.ra;
        vec_rd_ack    = s.rack;
        vec_rd_data   = s.rdat;
        push_ack      = s.pack;
        pc_now        = s.pc;
    endtask

    task automatic test_reset;
        row(st(1'b1,1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b0,32'h0,1'b0,32'h0), "reset_outputs",
            2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 5'b11111, 32'h0, RV, 32'h0, 32'h0);
        while (stim_q.size() > 0) begin
            exp_t e;
            drive(stim_q.pop_front());
            sb.push_back(pend_q.pop_front());
            #1;
            e = sb.pop_front();
            checks++;
            if ((obs & e.m) !== (e.v & e.m)) begin
                errors++;
                $display("[TB] FAIL %s: observed %h required %h", e.tag, obs & e.m, e.v & e.m);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_boot;
        row(st(1'b0,1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b0,32'h0,1'b0,32'h0), "boot_req_rises",
            2'b00,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 5'b00100, 32'h0, RV, 32'h0, 32'h0);
        row(st(1'b0,1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b0,32'h0,1'b0,32'h0), "boot_req_held",
            2'b00,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 5'b00100, 32'h0, RV, 32'h0, 32'h0);
        row(st(1'b0,1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b1,32'h20,1'b0,32'h0), "boot_ack_cycle",
            2'b00,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 5'b00100, 32'h0, RV, 32'h0, 32'h0);
        row(st(1'b0,1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b0,32'h0,1'b0,32'h0), "boot_load_pulse",
            2'b01,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 5'b01000, 32'h0, RV, 32'h0, 32'h20);
        row(st(1'b0,1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b0,32'h0,1'b0,32'h0), "boot_first_run",
            2'b00,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 5'b01000, 32'h0, RV, 32'h0, 32'h20);
        row(st(1'b0,1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b0,32'h0,1'b0,32'h0), "boot_steady",
            2'b00,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 5'b01000, 32'h0, RV, 32'h0, 32'h20);
        while (stim_q.size() > 0) begin
            exp_t e;
            drive(stim_q.pop_front());
            sb.push_back(pend_q.pop_front());
            #1;
            e = sb.pop_front();
            checks++;
            if ((obs & e.m) !== (e.v & e.m)) begin
                errors++;
                $display("[TB] FAIL %s: observed %h required %h", e.tag, obs & e.m, e.v & e.m);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_stall_branch;
        for (int i = 0; i < 3; i++) begin
            row(st(1'b0,1'b1,1'b0,1'b0,32'h0,1'b0,32'h0,1'b0,32'h0,1'b0,32'h0), "stall_hold",
                2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 5'b00000, 32'h0, RV, 32'h0, 32'h0);
        end
        row(st(1'b0,1'b1,1'b0,1'b1,32'h100,1'b0,32'h0,1'b0,32'h0,1'b0,32'h0), "branch_over_stall",
            2'b11,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 5'b00001, 32'h100, RV, 32'h0, 32'h0);
        row(st(1'b0,1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b0,32'h0,1'b0,32'h0), "after_branch",
            2'b00,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 5'b00000, 32'h0, RV, 32'h0, 32'h0);
        while (stim_q.size() > 0) begin
            exp_t e;
            drive(stim_q.pop_front());
            sb.push_back(pend_q.pop_front());
            #1;
            e = sb.pop_front();
            checks++;
            if ((obs & e.m) !== (e.v & e.m)) begin
                errors++;
                $display("[TB] FAIL %s: observed %h required %h", e.tag, obs & e.m, e.v & e.m);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_interrupt_entry;
        row(st(1'b0,1'b0,1'b1,1'b0,32'h0,1'b0,32'h0,1'b0,32'h0,1'b0,32'h44), "int_edge",
            2'b00,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 5'b00000, 32'h0, RV, 32'h0, 32'h0);
        row(st(1'b0,1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b0,32'h0,1'b0,32'h44), "int_ack",
            2'b00,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0, 5'b00000, 32'h0, RV, 32'h0, 32'h0);
        row(st(1'b0,1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b0,32'h0,1'b0,32'h0), "int_push_req",
            2'b00,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1, 5'b00010, 32'h0, RV, 32'h44, 32'h0);
        row(st(1'b0,1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b0,32'h0,1'b1,32'h0), "int_push_ack",
            2'b00,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1, 5'b00010, 32'h0, RV, 32'h44, 32'h0);
        row(st(1'b0,1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b1,32'h200,1'b0,32'h0), "int_vec_rd",
            2'b00,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1, 5'b00100, 32'h0, IV, 32'h0, 32'h0);
        row(st(1'b0,1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b0,32'h0,1'b0,32'h0), "int_jump",
            2'b11,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1, 5'b00001, 32'h200, RV, 32'h0, 32'h0);
        row(st(1'b0,1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b0,32'h0,1'b0,32'h0), "isr_run",
            2'b00,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1, 5'b00000, 32'h0, RV, 32'h0, 32'h0);
        while (stim_q.size() > 0) begin
            exp_t e;
            drive(stim_q.pop_front());
            sb.push_back(pend_q.pop_front());
            #1;
            e = sb.pop_front();
            checks++;
            if ((obs & e.m) !== (e.v & e.m)) begin
                errors++;
                $display("[TB] FAIL %s: observed %h required %h", e.tag, obs & e.m, e.v & e.m);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_nesting_reti;
        row(st(1'b0,1'b0,1'b1,1'b0,32'h0,1'b0,32'h0,1'b0,32'h0,1'b0,32'h0), "nest_edge",
            2'b00,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1, 5'b00000, 32'h0, RV, 32'h0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            row(st(1'b0,1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b0,32'h0,1'b0,32'h0), "nest_blocked",
                2'b00,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1, 5'b00000, 32'h0, RV, 32'h0, 32'h0);
        end
        row(st(1'b0,1'b0,1'b0,1'b0,32'h0,1'b1,32'h44,1'b0,32'h0,1'b0,32'h0), "reti_jump",
            2'b11,1'b1,1'b1,1'b0,1'b0,1'b0,1'b1, 5'b00001, 32'h44, RV, 32'h0, 32'h0);
        row(st(1'b0,1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b0,32'h0,1'b0,32'h48), "pend_enter",
            2'b00,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0, 5'b00000, 32'h0, RV, 32'h0, 32'h0);
        row(st(1'b0,1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b0,32'h0,1'b1,32'h0), "pend_push",
            2'b00,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1, 5'b00010, 32'h0, RV, 32'h48, 32'h0);
        row(st(1'b0,1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b1,32'h300,1'b0,32'h0), "pend_vec_rd",
            2'b00,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1, 5'b00100, 32'h0, IV, 32'h0, 32'h0);
        row(st(1'b0,1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b0,32'h0,1'b0,32'h0), "pend_jump",
            2'b11,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1, 5'b00001, 32'h300, RV, 32'h0, 32'h0);
        row(st(1'b0,1'b0,1'b0,1'b0,32'h0,1'b1,32'h48,1'b0,32'h0,1'b0,32'h0), "reti_second",
            2'b11,1'b1,1'b1,1'b0,1'b0,1'b0,1'b1, 5'b00001, 32'h48, RV, 32'h0, 32'h0);
        row(st(1'b0,1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b0,32'h0,1'b0,32'h0), "post_reti",
            2'b00,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 5'b00000, 32'h0, RV, 32'h0, 32'h0);
        while (stim_q.size() > 0) begin
            exp_t e;
            drive(stim_q.pop_front());
            sb.push_back(pend_q.pop_front());
            #1;
            e = sb.pop_front();
            checks++;
            if ((obs & e.m) !== (e.v & e.m)) begin
                errors++;
                $display("[TB] FAIL %s: observed %h required %h", e.tag, obs & e.m, e.v & e.m);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_collision;
        row(st(1'b0,1'b0,1'b1,1'b0,32'h0,1'b0,32'h0,1'b0,32'h0,1'b0,32'h0), "coll_edge",
            2'b00,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 5'b00000, 32'h0, RV, 32'h0, 32'h0);
        row(st(1'b0,1'b0,1'b0,1'b1,32'h80,1'b0,32'h0,1'b0,32'h0,1'b0,32'h7c), "coll_branch_wins",
            2'b11,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 5'b00001, 32'h80, RV, 32'h0, 32'h0);
        row(st(1'b0,1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b0,32'h0,1'b0,32'h80), "coll_int_ack",
            2'b00,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0, 5'b00000, 32'h0, RV, 32'h0, 32'h0);
        row(st(1'b0,1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b0,32'h0,1'b0,32'h0), "coll_push",
            2'b00,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1, 5'b00010, 32'h0, RV, 32'h80, 32'h0);
        row(st(1'b0,1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b0,32'h0,1'b1,32'h0), "coll_push_ack",
            2'b00,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1, 5'b00010, 32'h0, RV, 32'h80, 32'h0);
        row(st(1'b0,1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b0,32'h0,1'b0,32'h0), "coll_rd_wait",
            2'b00,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1, 5'b00100, 32'h0, IV, 32'h0, 32'h0);
        while (stim_q.size() > 0) begin
            exp_t e;
            drive(stim_q.pop_front());
            sb.push_back(pend_q.pop_front());
            #1;
            e = sb.pop_front();
            checks++;
            if ((obs & e.m) !== (e.v & e.m)) begin
                errors++;
                $display("[TB] FAIL %s: observed %h required %h", e.tag, obs & e.m, e.v & e.m);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_rd;
        row(st(1'b1,1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b0,32'h0,1'b0,32'h0), "rst_mid_rd",
            2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 5'b11111, 32'h0, RV, 32'h0, 32'h0);
        row(st(1'b1,1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b1,32'h999,1'b0,32'h0), "rst_late_ack",
            2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 5'b11111, 32'h0, RV, 32'h0, 32'h0);
        row(st(1'b0,1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b0,32'h0,1'b0,32'h0), "reboot_req",
            2'b00,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 5'b01100, 32'h0, RV, 32'h0, 32'h0);
        row(st(1'b0,1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b1,32'h40,1'b0,32'h0), "reboot_ack",
            2'b00,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 5'b01100, 32'h0, RV, 32'h0, 32'h0);
        row(st(1'b0,1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b0,32'h0,1'b0,32'h0), "reboot_load",
            2'b01,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 5'b01000, 32'h0, RV, 32'h0, 32'h40);
        row(st(1'b0,1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b0,32'h0,1'b0,32'h0), "reboot_run",
            2'b00,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 5'b01000, 32'h0, RV, 32'h0, 32'h40);
        while (stim_q.size() > 0) begin
            exp_t e;
            drive(stim_q.pop_front());
            sb.push_back(pend_q.pop_front());
            #1;
            e = sb.pop_front();
            checks++;
            if ((obs & e.m) !== (e.v & e.m)) begin
                errors++;
                $display("[TB] FAIL %s: observed %h required %h", e.tag, obs & e.m, e.v & e.m);
            end
            @(negedge clk);
        end
    endtask

    // Main sequence: each scenario starts on a falling edge and leaves the
    // sequencer in the state the next one expects.
    initial begin
        drive(st(1'b1,1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b0,32'h0,1'b0,32'h0));
        @(negedge clk);
        test_reset;
        test_boot;
        test_stall_branch;
        test_interrupt_entry;
        test_nesting_reti;
        test_collision;
        test_reset_mid_rd;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Guards against a run that never reaches the summary.
    initial begin
        #50000;
        $display("[TB] FAIL watchdog: observed no completion required completion by 50000");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Control-side counterpart of the PC select mux. It decides every cycle how the program counter advances, and drives the mux's select, enable, first-instruction address and branch/call address inputs.
- It owns the boot sequence: reads the reset vector from memory, then loads it into the PC.
- It owns interrupt entry: flushes, saves the return PC, pushes it, reads the interrupt vector, then jumps.
- It owns ISR return (reti).
- It sits between the hazard/branch logic in decode/execute, the data-memory port, and the PC register.

Parameters:
- RESET_VEC_ADDR, 32'h0000_0000: memory address holding the first-instruction address.
- INT_VEC_ADDR, 32'h0000_0001: memory address holding the ISR address.
- AW, 32: address/data width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- pc_now  in  AW  current PC value, used as the return address on interrupt entry
- stall  in  1  fetch freeze request from the hazard unit
- branch_taken  in  1  one-cycle pulse: jump/call/taken branch resolved
- branch_target  in  AW  target address valid with branch_taken
- reti_valid  in  1  one-cycle pulse: return-from-interrupt resolved
- reti_addr  in  AW  popped return address valid with reti_valid
- int_req  in  1  external interrupt, synchronous level
- vec_rd_ack  in  1  memory read data valid
- vec_rd_data  in  AW  memory read data
- push_ack  in  1  stack push accepted
- pc_sel  out  2  to mux: 00 next, 01 first_instruction_addr, 10 zero, 11 branch_call_addr
- pc_en  out  1  PC update enable
- first_instruction_addr  out  AW  latched reset vector
- branch_call_addr  out  AW  jump target
- flush  out  1  squash fetch/decode stages
- vec_rd_req  out  1  memory read request, held until ack
- vec_rd_addr  out  AW  read address
- push_req  out  1  stack push request, held until ack
- push_data  out  AW  saved return PC
- int_ack  out  1  one-cycle pulse on interrupt acceptance
- in_isr  out  1  high while servicing an interrupt

Behaviour:
- Reset (async):
  - State goes to BOOT_RD.
  - All outputs 0, except vec_rd_addr = RESET_VEC_ADDR.
  - Registers cleared: int_pend=0, in_isr=0, saved PC 0.
  - Reset asserted mid-sequence abandons any pending request immediately; no ack is awaited.
- States:
  - BOOT_RD: vec_rd_req=1, vec_rd_addr=RESET_VEC_ADDR, pc_en=0. On vec_rd_ack, latch vec_rd_data into first_instruction_addr, then go to BOOT_LD.
  - BOOT_LD: pc_sel=01, pc_en=1 for exactly one cycle, then go to RUN.
  - RUN: evaluated each cycle in priority order:
    1. branch_taken: pc_sel=11, branch_call_addr=branch_target (combinational), pc_en=1, flush=1. This overrides stall.
    2. reti_valid: same as a branch using reti_addr; also clears in_isr.
    3. int_pend && !in_isr && !stall: flush=1, int_ack=1, pc_en=0, latch saved PC = pc_now, set in_isr, clear int_pend, go to INT_PUSH.
    4. stall: pc_en=0.
    5. Otherwise: pc_sel=00, pc_en=1.
  - INT_PUSH: push_req=1, push_data=saved PC, pc_en=0. On push_ack, go to INT_RD.
  - INT_RD: vec_rd_req=1, vec_rd_addr=INT_VEC_ADDR, pc_en=0. On vec_rd_ack, latch data into the vector register and go to INT_JMP.
  - INT_JMP: pc_sel=11, branch_call_addr=vector register, pc_en=1 for one cycle, then go to RUN.
- Interrupt pending flag:
  - Set on a rising edge of int_req (registered previous value).
  - Stays set while in_isr or stall is high; nested interrupts are not taken.
  - Serviced in the first RUN cycle after reti that has no branch and no stall.
- Simultaneous events:
  - branch_taken with int_pend in the same cycle: the branch wins and the interrupt is taken on the next eligible cycle, so the saved PC is the branch target.
  - branch_taken and reti_valid in the same cycle is illegal (upstream guarantee); branch wins.
  - branch_taken or reti_valid outside RUN: ignored.
  - stall outside RUN: ignored.
  - A new int_req edge during an interrupt sequence sets int_pend.
- Handshakes:
  - Req/addr/data are stable from assertion until the ack cycle and drop the cycle after.
  - Ack may arrive in the same cycle req rises; the state then advances in 1 cycle.
  - There is no timeout.
- pc_sel=10 (zero) is never driven; it is reserved.
- Latency:
  - Boot is vec_rd latency + 1 cycles before the first PC load.
  - Interrupt entry is 1 + push latency + read latency + 1 cycles from int_ack to the PC load.

Test Plan:
- Boot: release rst, ack the read 2 cycles later with vec_rd_data=32'h20 -> first_instruction_addr=32'h20, one pc_sel=01/pc_en=1 pulse, then pc_sel=00/pc_en=1 steadily.
- Branch/stall: in RUN, hold stall 3 cycles -> pc_en=0 for 3 cycles. Then branch_taken with target 32'h100 while stall=1 -> pc_sel=11, branch_call_addr=32'h100, pc_en=1, flush=1.
- Interrupt entry:
  - Stimulus: pc_now=32'h44, rising edge on int_req, push_ack after 1 cycle, vec_rd_data=32'h200.
  - Required: int_ack pulse, push_data=32'h44, vec_rd_addr=INT_VEC_ADDR, then pc_sel=11 with 32'h200, in_isr=1.
- Nesting and reti:
  - Stimulus: second int_req edge inside the ISR, then reti_valid with reti_addr=32'h44.
  - Required: no entry while in ISR; PC jumps to 32'h44, in_isr drops, and the pending interrupt enters on the next clean RUN cycle.
- Collision: branch_taken (32'h80) in the same cycle an interrupt is pending -> branch taken first; next cycle int_ack with push_data=pc_now (32'h80).
- Async reset mid-INT_RD: assert rst between req and ack -> outputs 0 immediately, state BOOT_RD; a late vec_rd_ack is ignored until BOOT_RD issues its req.
